// File: rtl/mac_row_reducer_pkg.sv
// Shared constants and helpers for the mac_row_reducer slice.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package mac_row_reducer_pkg;

  // Bit positions inside the sticky err vector.
  localparam int ERR_ROW_DEC  = 0;
  localparam int ERR_OVERFLOW = 1;

  // Ceiling log2 for elaboration-time sizing; log2(16) = 4, log2(1) = 0.
  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous result FIFO with a registered read port.
// Latency: push visible to pop next cycle; dout updates the cycle after pop.
// Backpressure: push while full is ignored (caller flags the drop); pop while empty is ignored.
//
// Ports: clk/rst (sync active-high), push/din write side, pop/dout read side,
//        count (occupancy, log2(DEPTH)+1 bits), full, empty.
module mac_result_fifo
  import mac_row_reducer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CNT_W = log2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = log2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/mac_row_reducer.sv
// Multiplies (row, v0, v1) products and reduces runs of equal row into (row, sum, count) results.
// Latency: row-closing wr -> push_out 3 cycles; eof -> push_out of flushed row 4 cycles.
// Backpressure: stall_out holds the result FIFO; stall asks the producer to stop at occupancy >= DEPTH-2.
//
// Ports: clk/rst (sync active-high); wr/row/v0/v1/eof product stream in; stall to producer;
//        stall_out from consumer; push_out/row_out/v_out/count_out result strobe + data;
//        err sticky flags ([0] row decreased, [1] result dropped on full FIFO).
module mac_row_reducer
  import mac_row_reducer_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ACC_WIDTH   = 64,
  parameter int ROW_WIDTH   = 10,
  parameter int COUNT_WIDTH = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SIGNED      = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [ROW_WIDTH-1:0]   row,
  input  logic [DATA_WIDTH-1:0]  v0,
  input  logic [DATA_WIDTH-1:0]  v1,
  input  logic                   eof,
  output logic                   stall,
  input  logic                   stall_out,
  output logic                   push_out,
  output logic [ROW_WIDTH-1:0]   row_out,
  output logic [ACC_WIDTH-1:0]   v_out,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic [1:0]             err
);

  localparam int RES_W = ROW_WIDTH + ACC_WIDTH + COUNT_WIDTH;
  localparam int CNT_W = log2(FIFO_DEPTH) + 1;

  // Stage M
  logic                   m_valid;
  logic [ROW_WIDTH-1:0]   m_row;
  logic [ACC_WIDTH-1:0]   m_prod;
  logic                   eof_d1;
  logic                   eof_d2;

  // Stage A (open row accumulator)
  logic                   open;
  logic [ROW_WIDTH-1:0]   a_row;
  logic [ACC_WIDTH-1:0]   a_sum;
  logic [COUNT_WIDTH-1:0] a_cnt;

  logic [ACC_WIDTH-1:0]   op0;
  logic [ACC_WIDTH-1:0]   op1;
  logic [ACC_WIDTH-1:0]   prod;

  logic                   close_row;
  logic                   row_dec;
  logic                   fifo_pop;
  logic [RES_W-1:0]       fifo_din;
  logic [RES_W-1:0]       fifo_dout;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Operands are extended (or trimmed) to ACC_WIDTH before multiplying; the low
  // ACC_WIDTH bits of the product only depend on the low ACC_WIDTH operand bits,
  // so this gives the truncated true product for either signedness.
  always_comb begin
    if (SIGNED != 0) begin
      op0 = ACC_WIDTH'($signed(v0));
      op1 = ACC_WIDTH'($signed(v1));
    end else begin
      op0 = ACC_WIDTH'(v0);
      op1 = ACC_WIDTH'(v1);
    end
    prod = op0 * op1;
  end

  // The open row closes on a delayed eof or on a row change; never both counted,
  // so there is at most one enqueue per cycle.
  assign close_row = open && (eof_d2 || (m_valid && (m_row != a_row)));
  // A row change across an eof boundary starts a new stream and is not an error.
  assign row_dec   = open && m_valid && !eof_d2 && (m_row < a_row);
  assign fifo_pop  = !fifo_empty && !stall_out;
  assign fifo_din  = {a_row, a_sum, a_cnt};
  assign {row_out, v_out, count_out} = fifo_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_row    <= '0;
      m_prod   <= '0;
      eof_d1   <= 1'b0;
      eof_d2   <= 1'b0;
      open     <= 1'b0;
      a_row    <= '0;
      a_sum    <= '0;
      a_cnt    <= '0;
      stall    <= 1'b0;
      push_out <= 1'b0;
      err      <= '0;
    end else begin
      m_valid <= wr;
      m_row   <= row;
      m_prod  <= prod;
      eof_d1  <= eof;
      eof_d2  <= eof_d1;

      if (m_valid && (!open || close_row)) begin
        // Fresh row, including a same-index row arriving right after an eof flush.
        open  <= 1'b1;
        a_row <= m_row;
        a_sum <= m_prod;
        a_cnt <= COUNT_WIDTH'(1);
      end else if (m_valid) begin
        a_sum <= a_sum + m_prod;
        if (a_cnt != '1) a_cnt <= a_cnt + 1'b1;
      end else if (close_row) begin
        open <= 1'b0;
      end

      if (row_dec) err[ERR_ROW_DEC] <= 1'b1;
      if (close_row && fifo_full) err[ERR_OVERFLOW] <= 1'b1;

      stall    <= (fifo_count >= CNT_W'(FIFO_DEPTH - 2));
      push_out <= fifo_pop;
    end
  end

  mac_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (close_row),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
